// File: rtl/rmii_rx_framer.sv
// RMII receive framer: locks onto preamble/SFD, packs dibits LSB-first into bytes, checks CRC-32 by residue.
// Latency 2 cycles pin-to-output; no backpressure, bytes stream at line rate (one per 4 cycles at most).
module rmii_rx_framer #(
  parameter int MIN_PREAMBLE = 8,
  parameter int MAX_BYTES    = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eth_crsdv,
  input  logic [1:0]  eth_rxd,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        align_err,
  output logic        oversize_err,
  output logic [15:0] byte_count
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  localparam logic [31:0] LP_MAX     = 32'(MAX_BYTES);
  localparam logic [6:0]  LP_MIN     = 7'(MIN_PREAMBLE);
  localparam logic [31:0] LP_RESIDUE = 32'hDEBB20E3;

  state_t      r_state;
  logic        r_crsdv_q;
  logic [1:0]  r_rxd_q;
  logic [5:0]  r_pre_cnt;
  logic [1:0]  r_dibit_cnt;
  logic [7:0]  r_sr;
  logic [31:0] r_crc;

  logic [7:0]  w_byte;
  logic [31:0] w_crc_next;
  logic [15:0] w_cnt_next;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign w_byte     = {r_rxd_q, r_sr[7:2]};
  assign w_crc_next = crc_byte(r_crc, w_byte);
  assign w_cnt_next = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crsdv_q <= 1'b0;
      r_rxd_q   <= 2'b00;
    end else begin
      r_crsdv_q <= eth_crsdv;
      r_rxd_q   <= eth_rxd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pre_cnt    <= 6'd0;
      r_dibit_cnt  <= 2'd0;
      r_sr         <= 8'h00;
      r_crc        <= 32'hFFFFFFFF;
      byte_valid   <= 1'b0;
      byte_data    <= 8'h00;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
      crc_ok       <= 1'b0;
      align_err    <= 1'b0;
      oversize_err <= 1'b0;
      byte_count   <= 16'd0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // 00 dibits with CRS_DV high are PHY idle; anything but 01 is garbage
          if (r_crsdv_q) begin
            if (r_rxd_q == 2'b01) begin
              r_state   <= S_PREAMBLE;
              r_pre_cnt <= 6'd1;
            end else if (r_rxd_q != 2'b00) begin
              r_state <= S_DROP;
            end
          end
        end
        S_PREAMBLE: begin
          if (!r_crsdv_q) begin
            r_state <= S_IDLE;
          end else if (r_rxd_q == 2'b01) begin
            if (r_pre_cnt != 6'd63) r_pre_cnt <= r_pre_cnt + 6'd1;
          end else if (r_rxd_q == 2'b11 && {1'b0, r_pre_cnt} >= LP_MIN) begin
            r_state      <= S_DATA;
            frame_start  <= 1'b1;
            r_crc        <= 32'hFFFFFFFF;
            r_dibit_cnt  <= 2'd0;
            byte_count   <= 16'd0;
            crc_ok       <= 1'b0;
            align_err    <= 1'b0;
            oversize_err <= 1'b0;
          end else begin
            r_state <= S_DROP;
          end
        end
        S_DATA: begin
          if (r_crsdv_q) begin
            r_sr        <= w_byte;
            r_dibit_cnt <= r_dibit_cnt + 2'd1;
            if (r_dibit_cnt == 2'd3) begin
              byte_valid <= 1'b1;
              byte_data  <= w_byte;
              byte_count <= w_cnt_next;
              r_crc      <= w_crc_next;
              if ({16'd0, w_cnt_next} > LP_MAX) oversize_err <= 1'b1;
            end
          end else begin
            // a trailing partial byte is dropped and poisons the CRC verdict
            r_state    <= S_IDLE;
            frame_done <= 1'b1;
            align_err  <= (r_dibit_cnt != 2'd0);
            crc_ok     <= (r_crc == LP_RESIDUE) && (r_dibit_cnt == 2'd0);
          end
        end
        S_DROP: begin
          if (!r_crsdv_q) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rmii_rx_framer.md
# rmii_rx_framer

RMII receive-side framer: the inbound counterpart of the Ethernet transmit path on the 50 MHz reference clock. It samples the PHY's CRS_DV/RXD[1:0] dibit stream, locks onto the preamble and SFD, and reassembles payload dibits LSB-first into bytes. It checks the frame's CRC-32 by residue and reports per-frame status. It sits between the board RMII pins and the downstream packet parser/bit-order logic.

## Interface
- MIN_PREAMBLE, default 8: minimum consecutive 01 dibits required before SFD (the 01 dibits of the SFD's first three dibits count toward this).
- MAX_BYTES, default 1522: byte count above which oversize_err is set.
- clk  in  1  50 MHz RMII reference clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- eth_crsdv  in  1  RMII carrier-sense/data-valid.
- eth_rxd  in  2  RMII receive dibit.
- byte_valid  out  1  one-cycle strobe, byte_data valid.
- byte_data  out  8  assembled byte, first dibit in [1:0].
- frame_start  out  1  one-cycle pulse on SFD detection.
- frame_done  out  1  one-cycle pulse at end of a frame that reached DATA.
- crc_ok  out  1  FCS residue check result, valid with frame_done.
- align_err  out  1  frame ended on a non-byte boundary.
- oversize_err  out  1  byte_count exceeded MAX_BYTES.
- byte_count  out  16  bytes in frame, including FCS; saturates at 16'hFFFF.

## Operation
- Input stage: eth_crsdv/eth_rxd registered once (crsdv_q, rxd_q); FSM acts on registered values only.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: crsdv_q=1 & rxd_q=01 -> PREAMBLE, pre_cnt=1. crsdv_q=1 & rxd_q=00 -> stay (PHY idle dibits). crsdv_q=1 & rxd_q in {10,11} -> DROP.
- PREAMBLE: rxd_q=01 -> pre_cnt++ (saturate at 63). rxd_q=11 & pre_cnt>=MIN_PREAMBLE -> DATA, pulse frame_start, clear crc to 32'hFFFFFFFF, dibit_cnt=0, byte_count=0, clear crc_ok/align_err/oversize_err. rxd_q=11 with short preamble, or 00/10 -> DROP. crsdv_q=0 -> IDLE, no frame_done.
- DATA, crsdv_q=1: shift rxd_q into byte shift register at the top; dibit_cnt (2 bits) increments and wraps. On 4th dibit: byte_valid=1, byte_data = {rxd_q, sr[7:2]}, byte_count++, CRC updated with that byte; byte_count > MAX_BYTES sets oversize_err (sticky for the frame).
- DATA, crsdv_q=0: -> IDLE; frame_done=1; align_err = (dibit_cnt != 0), partial byte discarded, not strobed; crc_ok = (crc register == 32'hDEBB20E3) & ~align_err.
- DROP: wait for crsdv_q=0 -> IDLE; no outputs.
- CRC: reflected CRC-32, poly 32'hEDB88320, init 32'hFFFFFFFF, byte-wide update, no final XOR; FCS bytes included in the running CRC.
- CRS_DV toggling at end of carrier is not handled: one low sample ends the frame.
- Status outputs (crc_ok, align_err, oversize_err, byte_count) hold their values until the next frame_start.

## Timing
- Reset: state=IDLE; all outputs 0, byte_data=0, byte_count=0, crc register=32'hFFFFFFFF.
- Pin to FSM: 1 cycle. The SFD's 11 dibit on the pins at edge N gives frame_start high during cycle N+2.
- byte_valid: high the cycle after the 4th dibit of the byte is registered, 2 cycles after that dibit is on the pins; strobes at most every 4 cycles.
- frame_done: 2 cycles after the first low eth_crsdv on the pins. Final byte_valid and frame_done are never in the same cycle when aligned; frame_done is at least 1 cycle after the last byte_valid.
- Reset asserted mid-frame: immediate return to reset values; no frame_done.
- Frame directly followed by new preamble with a single low crsdv cycle: frame_done issued, next frame accepted normally.

## Test plan
- 28×01 + 01,01,01,11, then bytes FE ED BE EF sent LSB-dibit first, crsdv low -> frame_start once; byte_valid ×4 with FE, ED, BE, EF; byte_count=4; crc_ok=0; align_err=0.
- Preamble/SFD, then ASCII "123456789" (31..39) + FCS 26 39 F4 CB -> 13 byte strobes; frame_done with crc_ok=1, byte_count=13.
- Same frame with one payload dibit flipped -> crc_ok=0; remaining byte strobes unchanged in count.
- Same frame plus one extra dibit 10 before crsdv falls -> align_err=1, crc_ok=0, byte_count=13, no 14th strobe.
- Preamble of 4×01 then 11 (MIN_PREAMBLE=8) -> no frame_start, no byte_valid, no frame_done; the next valid frame is received normally. Preamble containing a 10 dibit gives the same result.
- Reset pulse after 2 bytes of payload -> all outputs 0 immediately, no frame_done; following good frame gives crc_ok=1.
